instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface: owns the fetch PC, issues word
//  fetches to a byte-addressed, little-endian instruction memory via req/ack, and buffers
//  {pc, instr} pairs in a small FIFO toward decode. Handles stalls and branch/jump
//  redirects, discarding in-flight wrong-path data. Sits between the PC/branch logic
//  and the decode stage.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset
//  FIFO_DEPTH  4              prefetch entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   asynchronous, active-high reset
//  redirect_valid  in   1   taken branch/jump: restart fetch at redirect_pc
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 00)
//  imem_req        out  1   fetch request to instruction memory
//  imem_addr       out  32  byte address of requested word (always 4-aligned)
//  imem_ack        in   1   memory returns imem_rdata this cycle (may be same cycle as req)
//  imem_rdata      in   32  fetched instruction word
//  if_valid        out  1   FIFO head holds a valid instruction
//  if_instr        out  32  instruction at FIFO head
//  if_pc           out  32  byte address of if_instr
//  if_ready        in   1   decode accepts head this cycle
// BEHAVIOUR
//  - Reset (async, immediate): fetch_pc=RESET_PC, FIFO count=0, state=FETCH; imem_req=0,
//    if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC while reset high.
//  - States: FETCH (normal), DISCARD (redirect arrived while a request awaited ack).
//  - FETCH: imem_req=1 when count<FIFO_DEPTH; imem_addr=fetch_pc. Once asserted, req and
//    addr stay stable until imem_ack (count only falls meanwhile, so full never drops req).
//  - On imem_ack in FETCH without redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4
//    (32-bit wrap, 0xFFFF_FFFC -> 0). Throughput 1 instr/cycle with same-cycle ack.
//  - Latency: ack in cycle N -> entry visible (if_valid=1) in cycle N+1.
//  - Pop when if_valid && if_ready. Push+pop same cycle: count unchanged. Full and no
//    outstanding req: imem_req=0 until a pop.
//  - Redirect (redirect_valid=1), any state: FIFO flushed (count=0, if_valid=0 next cycle),
//    pending pop ignored, redirect_pc&~3 stored as next fetch address.
//     * no req outstanding, or req acked this same cycle: data dropped, fetch_pc=target,
//       stay/return FETCH.
//     * req outstanding, not acked: go DISCARD; keep req=1 with old addr until ack.
//  - DISCARD: on ack drop data, fetch_pc=stored target, go FETCH. New redirect in DISCARD
//    overwrites stored target only. No pushes in DISCARD.
//  - if_instr/if_pc driven from FIFO head registers (no combinational path from imem_rdata).
//  - Reset mid-operation: all in-flight data and FIFO contents lost; fetch restarts at
//    RESET_PC on first clk edge after reset falls.
// TESTING
//  1. Reset release, ack tied to req, if_ready=1, mem word0=0x00140413 -> cycle0 addr=0x0,
//     cycle1 if_valid=1 if_pc=0x0 if_instr=0x00140413; addrs 0x4,0x8,... one per cycle.
//  2. if_ready=0 from start -> 4 pushes (pc 0x0..0xC), imem_req=0 with addr=0x10;
//     raise if_ready -> pops in order, req resumes at 0x10, no entry lost/duplicated.
//  3. Redirect to 0x4C same cycle as ack of 0x14 -> 0x14 data dropped, next cycle
//     if_valid=0, addr=0x4C; following cycle if_pc=0x4C.
//  4. ack delayed 3 cycles, redirect to 0x20 one cycle after req of 0x08 -> req/addr
//     held at 0x08 until ack, data discarded, next req addr=0x20, no 0x08 output.
//  5. redirect_pc=0x27 -> imem_addr=0x24; fetch_pc at 0xFFFF_FFFC acked -> next addr 0x0.
//  6. Assert reset with 3 entries buffered and req pending -> if_valid=0, imem_req=0
//     immediately; after release first addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Instruction-memory initiator. Owns the fetch PC, issues
//               word fetches over a req/ack handshake and buffers
//               {pc, instr} pairs in a small prefetch FIFO toward decode.
//               Branch/jump redirects flush the FIFO. A request that is
//               still in flight when a redirect arrives is allowed to
//               complete, and its wrong-path data is discarded.
//
// Parameters  : RESET_PC    fetch PC loaded on reset
//               FIFO_DEPTH  prefetch entries (power of 2, >= 2)
//
// Ports       : clk             clock, all state on rising edge
//               reset           asynchronous active-high reset
//               redirect_valid  restart fetch at redirect_pc
//               redirect_pc     redirect target (bits [1:0] ignored)
//               imem_req        fetch request to instruction memory
//               imem_addr       4-aligned byte address of requested word
//               imem_ack        memory returns imem_rdata this cycle
//               imem_rdata      fetched instruction word
//               if_valid        FIFO head holds a valid instruction
//               if_instr        instruction at FIFO head
//               if_pc           byte address of if_instr
//               if_ready        decode accepts head this cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // r_run stays low from reset until the first clock edge after reset
    // falls, keeping imem_req low for the whole reset interval.
    logic               r_run;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_target;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_pc_mem    [FIFO_DEPTH];
    logic [31:0]        r_instr_mem [FIFO_DEPTH];

    logic [31:0]        w_fetch_pc_next;
    logic [31:0]        w_target_next;
    logic [31:0]        w_redirect_target;
    logic               w_req;
    logic               w_ack;
    logic               w_push;
    logic               w_pop;

    assign w_redirect_target = redirect_pc & ~32'h0000_0003;

    // In FETCH, req only depends on occupancy. Without an ack nothing is
    // pushed, so occupancy can only fall while a request waits, and req
    // cannot drop before the ack. DISCARD always has a request in flight.
    assign w_req  = r_run & ((r_state == ST_DISCARD) | (r_count != c_FULL));
    assign w_ack  = w_req & imem_ack;
    assign w_push = (r_state == ST_FETCH) & w_ack & ~redirect_valid;
    assign w_pop  = (r_count != '0) & if_ready & ~redirect_valid;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign if_valid  = (r_count != '0);
    assign if_instr  = r_instr_mem[r_rd_ptr];
    assign if_pc     = r_pc_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, fetch PC and stored redirect target
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_target_next   = r_target;
        case (r_state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (w_req && !imem_ack) begin
                        // Request in flight: it must complete at the old
                        // address before fetch can move to the target.
                        w_state_next  = ST_DISCARD;
                        w_target_next = w_redirect_target;
                    end else begin
                        w_fetch_pc_next = w_redirect_target;
                    end
                end else if (w_push) begin
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    w_target_next = w_redirect_target;
                end
                if (w_ack) begin
                    // A redirect in the same cycle as the ack is the
                    // newest target, so it takes priority over r_target.
                    w_fetch_pc_next = redirect_valid ? w_redirect_target : r_target;
                    w_state_next    = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC, target and prefetch FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_target   <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc_mem[i]    <= 32'h0;
                r_instr_mem[i] <= 32'h0;
            end
        end else begin
            r_run      <= 1'b1;
            r_fetch_pc <= w_fetch_pc_next;
            r_target   <= w_target_next;

            if (redirect_valid) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
                    r_instr_mem[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr              <= r_wr_ptr + c_PTR_1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_ONE;
                    2'b01:   r_count <= r_count - c_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. Directed
//               scenarios plus a randomized run scored against a
//               stream-level model: accepted instructions must form a
//               consecutive PC sequence that restarts at each redirect
//               target, with data matching the memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        ack_gate;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0014_0413;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory answers combinationally whenever the bench opens ack_gate.
    assign imem_ack   = imem_req & ack_gate;
    assign imem_rdata = mem_word(imem_addr);

    instruction_fetch_unit #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the bench 1 time unit after the first edge following reset
    // release: cycle 0, the first cycle fetch may request.
    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ack_gate = 1'b0; if_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        ack_gate = 1'b1; if_ready = 1'b1;
        tick();
        settle();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_pc); end
        n_checks++; if (imem_addr !== c_RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, c_RESET_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL seq_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k)); end
            if (k > 0) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 1)) || if_instr !== mem_word(32'(4 * (k - 1)))) begin
                    n_fail++; $display("FAIL seq_out[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, if_valid, if_pc, if_instr, 32'(4 * (k - 1)), mem_word(32'(4 * (k - 1)))); end
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_pc;
        logic        seen_req;
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            settle();
            n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin
                n_fail++; $display("FAIL full_req: got req=%b addr=%h want req=0 addr=00000010", imem_req, imem_addr); end
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
                n_fail++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
            if (k == 0) tick();
        end
        if_ready = 1'b1;
        exp_pc = 32'h0; seen_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                n_checks++; if (imem_addr !== 32'h10) begin
                    n_fail++; $display("FAIL full_resume: got addr=%h want 00000010", imem_addr); end
            end
            if (if_valid) begin
                n_checks++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL full_drain: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        n_checks++; if (!seen_req || exp_pc !== 32'h30) begin
            n_fail++; $display("FAIL full_count: got seen_req=%b next_pc=%h want 1 and 00000030", seen_req, exp_pc); end
        if_ready = 1'b0;
    endtask

    task automatic test_redirect_on_ack();
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h4C;
        settle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_fail++; $display("FAIL rdack_pre: got req=%b addr=%h want req=1 addr=00000014", imem_req, imem_addr); end
        tick();
        redirect_valid = 1'b0;
        settle();
        n_checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h4C) begin
            n_fail++; $display("FAIL rdack_flush: got v=%b addr=%h want v=0 addr=0000004c", if_valid, imem_addr); end
        tick();
        settle();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4C || if_instr !== mem_word(32'h4C)) begin
            n_fail++; $display("FAIL rdack_target: got v=%b pc=%h instr=%h want v=1 pc=0000004c instr=%h", if_valid, if_pc, if_instr, mem_word(32'h4C)); end
    endtask

    task automatic test_redirect_discard();
        logic saw_bad;
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b1; saw_bad = 1'b0;
        repeat (2) tick();
        for (int c = 2; c < 9; c++) begin
            ack_gate       = (c < 2 || c >= 5);
            redirect_valid = (c == 3);
            redirect_pc    = 32'h20;
            settle();
            if (if_valid && if_pc == 32'h08) saw_bad = 1'b1;
            if (c >= 2 && c <= 5) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h08) begin
                    n_fail++; $display("FAIL disc_hold[%0d]: got req=%b addr=%h want req=1 addr=00000008", c, imem_req, imem_addr); end
            end
            if (c == 6) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
                    n_fail++; $display("FAIL disc_next: got req=%b addr=%h want req=1 addr=00000020", imem_req, imem_addr); end
            end
            if (c == 7) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h20) begin
                    n_fail++; $display("FAIL disc_target: got v=%b pc=%h want v=1 pc=00000020", if_valid, if_pc); end
            end
            tick();
        end
        redirect_valid = 1'b0;
        n_checks++; if (saw_bad !== 1'b0) begin
            n_fail++; $display("FAIL disc_leak: got wrong-path pc 00000008 on output, want none"); end
    endtask

    task automatic test_align_wrap();
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h27;
        tick();
        settle();
        n_checks++; if (imem_addr !== 32'h24) begin
            n_fail++; $display("FAIL align: got addr=%h want 00000024", imem_addr); end
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        settle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_pre: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        tick();
        settle();
        n_checks++; if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_instr !== mem_word(32'hFFFF_FFFC)) begin
            n_fail++; $display("FAIL wrap: got addr=%h pc=%h instr=%h want addr=0 pc=fffffffc instr=%h", imem_addr, if_pc, if_instr, mem_word(32'hFFFF_FFFC)); end
        tick();
        settle();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        ack_gate = 1'b1; if_ready = 1'b0;
        repeat (3) tick();
        ack_gate = 1'b0;
        settle();
        n_checks++; if (if_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0C) begin
            n_fail++; $display("FAIL mid_pre: got v=%b req=%b addr=%h want v=1 req=1 addr=0000000c", if_valid, imem_req, imem_addr); end
        reset = 1'b1;
        settle();
        n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== c_RESET_PC || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b req=%b addr=%h pc=%h instr=%h want all idle", if_valid, imem_req, imem_addr, if_pc, if_instr); end
        tick();
        reset = 1'b0; ack_gate = 1'b1; if_ready = 1'b1;
        tick();
        settle();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== c_RESET_PC) begin
            n_fail++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, c_RESET_PC); end
        tick();
        settle();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== c_RESET_PC) begin
            n_fail++; $display("FAIL mid_first: got v=%b pc=%h want v=1 pc=%h", if_valid, if_pc, c_RESET_PC); end
    endtask

    // Random traffic. Expected behaviour at stream level: accepted
    // instructions follow exp_pc, exp_pc advances by 4 per accept and
    // jumps to the aligned target on every redirect.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_wait;
        logic        prev_redirect;
        int          pops;
        do_reset();
        exp_pc = c_RESET_PC; prev_wait = 1'b0; prev_redirect = 1'b0;
        prev_addr = 32'h0; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            ack_gate       = ($urandom_range(0, 9) < 6);
            if_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            settle();
            if (imem_req) begin
                n_checks++; if (imem_addr[1:0] !== 2'b00) begin
                    n_fail++; $display("FAIL rnd_align[%0d]: got addr=%h want 4-aligned", i, imem_addr); end
            end else begin
                n_checks++; if (if_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_idle[%0d]: got req=0 with v=%b want v=1 (full)", i, if_valid); end
            end
            if (prev_wait) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_fail++; $display("FAIL rnd_stable[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, prev_addr); end
            end
            if (prev_redirect) begin
                n_checks++; if (if_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_flush[%0d]: got v=%b want 0", i, if_valid); end
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (if_valid && if_ready) begin
                n_checks++; if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_stream[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, if_pc, if_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_wait     = imem_req && !imem_ack;
            prev_addr     = imem_addr;
            prev_redirect = redirect_valid;
            tick();
        end
        redirect_valid = 1'b0;
        n_checks++; if (pops < 200) begin
            n_fail++; $display("FAIL rnd_progress: got %0d accepts want at least 200", pops); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full_stall();
        test_redirect_on_ack();
        test_redirect_discard();
        test_align_wrap();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
